// File: rtl/gpi.sv
// General-purpose input core for the MMIO slot bus.
// Synchronises W input pins, latches enabled rising/falling edges into sticky
// write-1-to-clear flags and raises a level interrupt for enabled pending flags.
//
// Word map (addr[4:3] must be 0, otherwise reads return 0 and writes are dropped):
//   0 DATA      synchronised pin levels, read-only
//   1 EDGE_CAP  sticky edge flags, write 1 to clear
//   2 RISE_EN   per-pin rising-edge capture enable
//   3 FALL_EN   per-pin falling-edge capture enable
//   4 IRQ_EN    per-pin interrupt enable
//   5..7        reserved, read 0
module gpi #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [W-1:0]  din,
  output logic          irq
);

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_EDGE_CAP = 3'd1;
  localparam logic [2:0] REG_RISE_EN  = 3'd2;
  localparam logic [2:0] REG_FALL_EN  = 3'd3;
  localparam logic [2:0] REG_IRQ_EN   = 3'd4;

  // Synchroniser stages: s1 may be metastable, s2 is the clean level,
  // s3 is s2 one clock later and is used only to find transitions.
  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] s3_q, s3_d;

  // Software-visible state.
  logic [W-1:0] edge_cap_q, edge_cap_d;
  logic [W-1:0] rise_en_q,  rise_en_d;
  logic [W-1:0] fall_en_q,  fall_en_d;
  logic [W-1:0] irq_en_q,   irq_en_d;

  // Per-pin transition and capture qualifiers.
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] hit;
  logic [W-1:0] w1c_mask;

  // Bus decode.
  logic wr_en;
  logic in_window;
  logic wr_cap;
  logic wr_rise;
  logic wr_fall;
  logic wr_irq;

  // Reads are side-effect free, so the read strobe and the write data bits
  // above W carry no information for this core.
  logic unused_bus;
  assign unused_bus = ^{read, wr_data};

  // Decode a register write; accesses outside the 8-word window are dropped.
  always_comb begin
    wr_en     = cs & write;
    in_window = (addr[4:3] == 2'b00);
    wr_cap    = wr_en & in_window & (addr[2:0] == REG_EDGE_CAP);
    wr_rise   = wr_en & in_window & (addr[2:0] == REG_RISE_EN);
    wr_fall   = wr_en & in_window & (addr[2:0] == REG_FALL_EN);
    wr_irq    = wr_en & in_window & (addr[2:0] == REG_IRQ_EN);
  end

  // Per-pin edge detection against the delayed copy, qualified by the enables.
  // Only s2/s3 are compared, so an enable written now can only see transitions
  // of s2 that happen afterwards: no retroactive capture.
  for (genvar gi = 0; gi < W; gi++) begin : g_edge
    assign rise[gi]     = s2_q[gi] & ~s3_q[gi];
    assign fall[gi]     = ~s2_q[gi] & s3_q[gi];
    assign hit[gi]      = (rise[gi] & rise_en_q[gi]) | (fall[gi] & fall_en_q[gi]);
    assign w1c_mask[gi] = wr_cap & wr_data[gi];
  end

  // Next-state for the synchroniser chain and all software registers.
  // A fresh hit is ORed in after the clear so it survives a colliding W1C.
  always_comb begin
    s1_d       = din;
    s2_d       = s1_q;
    s3_d       = s2_q;
    edge_cap_d = (edge_cap_q & ~w1c_mask) | hit;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_en_d   = irq_en_q;
    if (wr_rise) begin
      rise_en_d = wr_data[W-1:0];
    end
    if (wr_fall) begin
      fall_en_d = wr_data[W-1:0];
    end
    if (wr_irq) begin
      irq_en_d = wr_data[W-1:0];
    end
  end

  // State registers; reset clears everything, including the sync chain,
  // so the post-reset refill from din is seen with all enables at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_en_q   <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      edge_cap_q <= edge_cap_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_en_q   <= irq_en_d;
    end
  end

  // Read mux on address alone; the slot bus qualifies it with cs/read.
  always_comb begin
    rd_data = '0;
    if (addr[4:3] == 2'b00) begin
      case (addr[2:0])
        REG_DATA:     rd_data[W-1:0] = s2_q;
        REG_EDGE_CAP: rd_data[W-1:0] = edge_cap_q;
        REG_RISE_EN:  rd_data[W-1:0] = rise_en_q;
        REG_FALL_EN:  rd_data[W-1:0] = fall_en_q;
        REG_IRQ_EN:   rd_data[W-1:0] = irq_en_q;
        default:      rd_data = '0;
      endcase
    end
  end

  // Interrupt is a pure AND-OR of registers, so it cannot glitch and drops
  // immediately when reset clears the flags.
  assign irq = |(edge_cap_q & irq_en_q);

endmodule

// File: tb/tb_gpi.sv
// Self-checking bench for gpi: directed scenarios with constant expectations,
// then randomized traffic checked against a behavioural model.
module tb_gpi;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cs;
  logic          read;
  logic          write;
  logic [4:0]    addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic [W-1:0]  din;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rd;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  gpi #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .din     (din),
    .irq     (irq)
  );

  // ---------------- behavioural reference model ----------------
  // m_hist holds the last three din samples (newest in the low slice).
  // The core sees pins two clocks late: the visible level is the sample
  // taken one edge before the latest, and a transition is a difference
  // between that level and the sample one edge older still.
  logic [3*W-1:0] m_hist;
  logic [W-1:0]   m_cap, m_rise, m_fall, m_ien;
  logic [W-1:0]   m_view, m_prev, m_hit, m_clr;
  logic           m_wr, m_irq;

  assign m_view = m_hist[2*W-1:W];
  assign m_prev = m_hist[3*W-1:2*W];
  assign m_hit  = (m_view & ~m_prev & m_rise) | (~m_view & m_prev & m_fall);
  assign m_wr   = cs && write && (addr[4:3] == 2'b00);
  assign m_clr  = (m_wr && addr[2:0] == 3'd1) ? wr_data[W-1:0] : '0;
  assign m_irq  = |(m_cap & m_ien);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hist <= '0;
      m_cap  <= '0;
      m_rise <= '0;
      m_fall <= '0;
      m_ien  <= '0;
    end else begin
      m_hist <= {m_hist[2*W-1:0], din};
      m_cap  <= (m_cap & ~m_clr) | m_hit;
      if (m_wr && addr[2:0] == 3'd2) m_rise <= wr_data[W-1:0];
      if (m_wr && addr[2:0] == 3'd3) m_fall <= wr_data[W-1:0];
      if (m_wr && addr[2:0] == 3'd4) m_ien  <= wr_data[W-1:0];
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    if (a[4:3] == 2'b00) begin
      case (a[2:0])
        3'd0:    r[W-1:0] = m_hist[2*W-1:W];
        3'd1:    r[W-1:0] = m_cap;
        3'd2:    r[W-1:0] = m_rise;
        3'd3:    r[W-1:0] = m_fall;
        3'd4:    r[W-1:0] = m_ien;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // ---------------- monitors ----------------
  // Read scoreboard: whenever a read is presented, pop and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && cs && read) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read: addr=%0d rd_data=%h with no expectation queued", addr, rd_data);
        end else begin
          exp_t x;
          x = sb.pop_front();
          if (rd_data !== x.rd) begin
            failures++;
            $display("FAIL %s: addr=%0d rd_data=%h expected %h", x.name, addr, rd_data, x.rd);
          end else begin
            $display("read  %-14s addr=%0d rd_data=%h", x.name, addr, rd_data);
          end
        end
      end
    end
  end

  // Interrupt follows the model on every cycle.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (irq !== m_irq) begin
        failures++;
        $display("FAIL irq_track: t=%0t irq=%b expected %b", $time, irq, m_irq);
      end
    end
  end

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
    $display("write addr=%0d wr_data=%h", a, d);
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
    exp_t x;
    x.rd = e;
    x.name = nm;
    sb.push_back(x);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    @(posedge clk);
    #1;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string nm);
    checks++;
    if (irq !== e) begin
      failures++;
      $display("FAIL %s: irq=%b expected %b", nm, irq, e);
    end else begin
      $display("irq   %-14s irq=%b", nm, irq);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; din = 8'hA5;

    // Reset / idle
    repeat (3) @(posedge clk);
    #1;
    chk_irq(1'b0, "irq_in_reset");
    reset_n = 1'b1;
    tick(1);
    rd(5'd0, 32'h0, "data_edge1");
    rd(5'd0, 32'hA5, "data_edge2");
    rd(5'd1, 32'h0, "cap_reset");
    rd(5'd2, 32'h0, "rise_reset");
    rd(5'd3, 32'h0, "fall_reset");
    rd(5'd4, 32'h0, "ien_reset");

    // Rising capture and irq latency
    din = 8'h00;
    tick(4);
    wr(5'd2, 32'h01);
    wr(5'd4, 32'h01);
    din[0] = 1'b1;
    tick(1);
    rd(5'd1, 32'h0, "cap_edge_k");
    chk_irq(1'b0, "irq_edge_k1");
    rd(5'd1, 32'h0, "cap_edge_k1");
    chk_irq(1'b1, "irq_edge_k2");
    rd(5'd1, 32'h01, "cap_edge_k2");
    wr(5'd1, 32'h01);
    chk_irq(1'b0, "irq_after_w1c");
    rd(5'd1, 32'h0, "cap_after_w1c");

    // Falling edge, then both-edge pulse
    din[7] = 1'b1;
    tick(4);
    wr(5'd3, 32'h80);
    din[7] = 1'b0;
    tick(3);
    rd(5'd1, 32'h80, "cap_fall7");
    chk_irq(1'b0, "irq_masked7");
    wr(5'd1, 32'h80);
    wr(5'd2, 32'h08);
    wr(5'd3, 32'h08);
    din[3] = 1'b1;
    tick(3);
    din[3] = 1'b0;
    tick(4);
    rd(5'd1, 32'h08, "cap_both3");
    tick(5);
    rd(5'd1, 32'h08, "cap_both3_hold");

    // W1C colliding with a new hit
    wr(5'd1, 32'hFF);
    wr(5'd2, 32'h03);
    din[1:0] = 2'b00;
    tick(4);
    din[1:0] = 2'b11;
    tick(4);
    rd(5'd1, 32'h03, "cap_pending01");
    din[0] = 1'b0;
    tick(4);
    din[0] = 1'b1;
    tick(2);
    wr(5'd1, 32'h03);
    rd(5'd1, 32'h01, "w1c_collide");

    // Masking and map holes
    wr(5'd1, 32'hFF);
    wr(5'd2, 32'h04);
    din[2] = 1'b1;
    tick(4);
    rd(5'd1, 32'h04, "cap_rise2");
    wr(5'd4, 32'h04);
    chk_irq(1'b1, "irq_en_on");
    wr(5'd4, 32'h00);
    chk_irq(1'b0, "irq_en_off");
    rd(5'd1, 32'h04, "cap_kept");
    wr(5'd4, 32'h04);
    chk_irq(1'b1, "irq_en_again");
    wr(5'd0, 32'hFFFFFFFF);
    wr(5'd5, 32'hFFFFFFFF);
    wr(5'd9, 32'hFFFFFFFF);
    rd(5'd1, 32'h04, "hole_cap");
    rd(5'd2, 32'h04, "hole_rise");
    rd(5'd3, 32'h08, "hole_fall");
    rd(5'd4, 32'h04, "hole_ien");
    rd(5'd5, 32'h0, "read_addr5");
    rd(5'd9, 32'h0, "read_addr9");
    rd(5'd0, 32'h07, "data_static");
    wr(5'd2, 32'hFFFFFFFF);
    rd(5'd2, 32'hFF, "rise_width");
    chk_irq(1'b1, "irq_before_rst");

    // Asynchronous reset between edges
    #1 reset_n = 1'b0;
    #1 chk_irq(1'b0, "irq_async_rst");
    #1 reset_n = 1'b1;
    tick(1);
    rd(5'd1, 32'h0, "rst_cap");
    rd(5'd2, 32'h0, "rst_rise");
    rd(5'd3, 32'h0, "rst_fall");
    rd(5'd4, 32'h0, "rst_ien");
    tick(4);
    rd(5'd1, 32'h0, "rst_no_capture");
    rd(5'd0, 32'h07, "rst_refill");
    wr(5'd2, 32'hFF);
    wr(5'd3, 32'hFF);
    tick(4);
    rd(5'd1, 32'h0, "static_no_cap");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rnd;
      logic [4:0]  a;
      int unsigned op;
      rnd = $urandom;
      op  = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) din = din ^ rnd[W-1:0];
      if (i == 300) begin
        #1 reset_n = 1'b0;
        #1 chk_irq(1'b0, "rnd_async_rst");
        #1 reset_n = 1'b1;
        tick(1);
      end
      rnd = $urandom;
      if (op < 4) begin
        a = (op < 3) ? 5'($urandom_range(1, 4)) : 5'($urandom_range(0, 31));
        wr(a, rnd);
      end else if (op < 8) begin
        a = (op < 7) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        rd(a, model_read(a), "rnd_read");
      end else begin
        tick(1);
      end
    end

    tick(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
